// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST field extractor.
package fast_pkg;

  // Bit 7 of every FAST byte marks the last byte of a field.
  localparam int STOP_BIT   = 7;

  // Widest stop-bit window the helper function can encode.
  localparam int SCAN_MAX   = 64;
  localparam int SCAN_IDX_W = $clog2(SCAN_MAX);

  typedef enum logic [0:0] {
    SCAN    = 1'b0,
    DISCARD = 1'b1
  } fx_state_t;

  typedef struct packed {
    logic                  found;
    logic [SCAN_IDX_W-1:0] index;
  } stop_hit_t;

  // Lowest set bit among the first n lanes of a stop-bit window.
  function automatic stop_hit_t first_stop(input logic [SCAN_MAX-1:0] window, input int n);
    stop_hit_t hit;
    hit = '0;
    // Walk from the top down so the lowest qualifying lane is written last.
    for (int i = SCAN_MAX - 1; i >= 0; i--) begin
      if (i < n && window[i]) begin
        hit.found = 1'b1;
        hit.index = SCAN_IDX_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/fast_stop_scan.sv
// Combinational priority encoder over the stop bits of an already
// rotated byte window; only the first n_valid lanes take part.
module fast_stop_scan
  import fast_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [8*LANES-1:0]         window,
  input  logic [$clog2(LANES+1)-1:0] n_valid,
  output logic                       found,
  output logic [$clog2(LANES)-1:0]   index
);

  localparam int IW = $clog2(LANES);

  logic [SCAN_MAX-1:0] stops;
  stop_hit_t           hit;

  // Gather stop bits lane by lane and pick the lowest one in range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stops = '0;
    for (int i = 0; i < LANES; i++) begin
      stops[i] = window[8*i + STOP_BIT];
    end
    hit   = first_stop(stops, int'(n_valid));
    found = hit.found;
    index = IW'(hit.index);
  end

endmodule

// File: rtl/fast_field_extractor.sv
// Byte ring plus stop-bit framer: accepts partial FAST beats and emits one
// left-aligned field per cycle, truncating and resynchronising on overlong fields.
module fast_field_extractor
  import fast_pkg::*;
#(
  parameter int BEAT_BYTES      = 8,
  parameter int RING_BYTES      = 32,
  parameter int MAX_FIELD_BYTES = 8,
  parameter int CNT_W           = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*BEAT_BYTES-1:0]            in_data,
  input  logic [$clog2(BEAT_BYTES+1)-1:0]    in_keep,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [8*MAX_FIELD_BYTES-1:0]       out_data,
  output logic [$clog2(MAX_FIELD_BYTES+1)-1:0] out_len,
  output logic                               out_err,
  output logic [CNT_W-1:0]                   drop_cnt
);

  localparam int AW = $clog2(RING_BYTES);          // ring address width
  localparam int PW = AW + 1;                      // pointer width incl. wrap bit
  localparam int NW = $clog2(MAX_FIELD_BYTES + 1); // lane count / length width
  localparam int IW = $clog2(MAX_FIELD_BYTES);     // lane index width

  logic [7:0]                   ring [RING_BYTES];
  logic [PW-1:0]                wr_ptr, rd_ptr, count, free_cnt, lane_cap, pop_n, drop_add;
  fx_state_t                    state, state_nx;
  logic [8*MAX_FIELD_BYTES-1:0] window, load_data;
  logic [NW-1:0]                scan_n, load_len;
  logic [IW-1:0]                stop_idx;
  logic                         stop_found, push, out_free, load, load_err;
  logic [CNT_W:0]               drop_sum;

  assign count    = wr_ptr - rd_ptr;
  assign free_cnt = PW'(RING_BYTES) - count;
  // Space check uses the registered count only; same-cycle pops give no credit.
  assign in_ready = free_cnt >= PW'(BEAT_BYTES);
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_add);

  // Rotate the ring so lane 0 of the window is the byte at rd_ptr.
  always_comb begin
    window = '0;
    for (int i = 0; i < MAX_FIELD_BYTES; i++) begin
      window[8*i +: 8] = ring[AW'(rd_ptr[AW-1:0] + AW'(i))];
    end
  end

  // SCAN looks at up to a full field; DISCARD only at up to one beat.
  always_comb begin
    lane_cap = (state == DISCARD) ? PW'(BEAT_BYTES) : PW'(MAX_FIELD_BYTES);
    scan_n   = (count < lane_cap) ? NW'(count) : NW'(lane_cap);
  end

  fast_stop_scan #(.LANES(MAX_FIELD_BYTES)) u_scan (
    .window  (window),
    .n_valid (scan_n),
    .found   (stop_found),
    .index   (stop_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= SCAN;
    else        state <= state_nx;
  end

  // Next-state: enter DISCARD after an overlong field, leave on the next stop.
  always_comb begin
    state_nx = state;
    case (state)
      SCAN:    if (!stop_found && count >= PW'(MAX_FIELD_BYTES) && out_free) state_nx = DISCARD;
      DISCARD: if (stop_found) state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
  end

  // Per-state actions: what to load into the output register, pop and drop.
  always_comb begin
    load     = 1'b0;
    load_err = 1'b0;
    load_len = '0;
    pop_n    = '0;
    drop_add = '0;
    case (state)
      SCAN: begin
        if (out_free) begin
          if (stop_found) begin
            load     = 1'b1;
            load_len = NW'(stop_idx) + NW'(1);
            pop_n    = PW'(stop_idx) + PW'(1);
          end else if (count >= PW'(MAX_FIELD_BYTES)) begin
            load     = 1'b1;
            load_err = 1'b1;
            load_len = NW'(MAX_FIELD_BYTES);
            pop_n    = PW'(MAX_FIELD_BYTES);
          end
        end
      end
      DISCARD: begin
        pop_n    = stop_found ? PW'(stop_idx) + PW'(1) : PW'(scan_n);
        drop_add = pop_n;
      end
      default: ;
    endcase
  end

  // Left-aligned field with every byte at or above the length forced to zero.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < MAX_FIELD_BYTES; i++) begin
      if (NW'(i) < load_len) load_data[8*i +: 8] = window[8*i +: 8];
    end
  end

  // Pointer update; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (push ? PW'(in_keep) : PW'(0));
      rd_ptr <= rd_ptr + pop_n;
    end
  end

  // Ring storage: write the kept bytes of an accepted beat.
  // NOTE: the ring has no reset; resetting the pointers already makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        if (k < int'(in_keep)) ring[AW'(wr_ptr[AW-1:0] + AW'(k))] <= in_data[8*k +: 8];
      end
    end
  end

  // Output register: loads only when free, otherwise holds its field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_len   <= load_len;
      out_err   <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of bytes thrown away while resynchronising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             drop_cnt <= '0;
    else if (drop_sum[CNT_W]) drop_cnt <= '1;
    else                    drop_cnt <= drop_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_fast_field_extractor.sv
// Directed and streamed stimulus for fast_field_extractor, checked against a
// byte-stream framing model and a few hand-computed fields.
module tb_fast_field_extractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_keep;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_len;
  logic        out_err;
  logic [15:0] drop_cnt;

  fast_field_extractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_err   (out_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          len;
    bit          err;
    int          cyc;
  } fld_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  fld_t exp_q[$];
  fld_t rx_q[$];
  logic [7:0] pending[$];
  bit   discarding = 0;
  int   model_drops = 0;
  bit   hold_v = 0;
  logic [69:0] hold_val;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Framing model: a field ends at the first byte with bit 7 set; eight bytes
  // without one become a truncated error field, and everything up to and
  // including the next stop byte is thrown away.
  task automatic model_emit(input bit err);
    fld_t f;
    f.data = '0;
    for (int i = 0; i < pending.size(); i++) f.data[8*i +: 8] = pending[i];
    f.len = pending.size();
    f.err = err;
    f.cyc = 0;
    exp_q.push_back(f);
    pending.delete();
  endtask

  task automatic model_push(input logic [63:0] d, input int keep);
    logic [7:0] b;
    for (int k = 0; k < keep; k++) begin
      b = d[8*k +: 8];
      if (discarding) begin
        model_drops++;
        if (b[7]) discarding = 0;
      end else begin
        pending.push_back(b);
        if (b[7]) model_emit(1'b0);
        else if (pending.size() == 8) begin
          model_emit(1'b1);
          discarding = 1;
        end
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pending.delete();
    rx_q.delete();
    discarding  = 0;
    model_drops = 0;
  endtask

  // Compare process: every accepted field against the model, plus stability while stalled.
  always @(negedge clk) begin
    fld_t e, r;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) check("held_output_stable", {out_valid, out_err, out_len, out_data}, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_field", {out_len, out_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check("field_data", out_data, e.data);
          check("field_len", out_len, e.len);
          check("field_err", out_err, e.err);
        end
        r.data = out_data; r.len = out_len; r.err = out_err; r.cyc = cyc;
        rx_q.push_back(r);
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_valid, out_err, out_len, out_data};
    end
  end

  // Drive one beat and wait (bounded) until it is accepted.
  task automatic send_beat(input logic [63:0] d, input int keep);
    int waited = 0;
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = 4'(keep);
    while (!ok) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else if (++waited > 2000) begin
        check("in_ready_wait", in_ready, 1);
        ok = 1;
      end
    end
    @(posedge clk); #1;
    model_push(d, keep);
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
  endtask

  task automatic wait_drain(input int budget);
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_rx(input int i, input logic [63:0] d, input int len, input bit err);
    if (i < rx_q.size()) begin
      check($sformatf("rx%0d_data", i), rx_q[i].data, d);
      check($sformatf("rx%0d_len", i), rx_q[i].len, len);
      check($sformatf("rx%0d_err", i), rx_q[i].err, err);
    end else begin
      check($sformatf("rx%0d_present", i), rx_q.size(), i + 1);
    end
  endtask

  logic [7:0] stream[$];
  bit         done;
  bit         saw_stall;
  int         n_fields, n_err, total_bytes;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_len", out_len, 0);
    check("rst_out_err", out_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: four fields in one beat, one per cycle, first one cycle after acceptance.
    rx_q.delete();
    send_beat(64'h88_07_86_05_04_83_82_01, 8);
    check("t1_not_yet_valid", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_after_one", out_valid, 1);
    wait_drain(50);
    check("t1_count", rx_q.size(), 4);
    check_rx(0, 64'h8201, 2, 0);
    check_rx(1, 64'h83, 1, 0);
    check_rx(2, 64'h86_05_04, 3, 0);
    check_rx(3, 64'h88_07, 2, 0);
    for (int i = 1; i < rx_q.size(); i++) check("t1_back_to_back", rx_q[i].cyc - rx_q[0].cyc, i);

    // 2: field split over two partial beats; bytes above in_keep carry stop bits and must be ignored.
    rx_q.delete();
    send_beat(64'hFFFF_FFFF_FF12_1110, 3);
    @(posedge clk); #1;
    check("t2_no_field_yet", out_valid, 0);
    send_beat(64'hFFFF_FFFF_FFFF_9413, 2);
    check("t2_not_yet_valid", out_valid, 0);
    @(posedge clk); #1;
    check("t2_valid_after_one", out_valid, 1);
    wait_drain(50);
    check("t2_count", rx_q.size(), 1);
    check_rx(0, 64'h94_13_12_11_10, 5, 0);

    // 3: overlong field, discard of 08 89, then a clean field.
    rx_q.delete();
    send_beat(64'h07_06_05_04_03_02_01_00, 8);
    send_beat(64'hFFFF_FFFF_FF81_8908, 3);
    wait_drain(50);
    check("t3_count", rx_q.size(), 2);
    check_rx(0, 64'h07_06_05_04_03_02_01_00, 8, 1);
    check_rx(1, 64'h81, 1, 0);
    check("t3_drop_cnt", drop_cnt, 2);
    check("t3_drop_model", drop_cnt, model_drops);

    // 4: backpressure under continuous full beats.
    rx_q.delete();
    saw_stall = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          logic [63:0] d;
          for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(((8*b + k) & 8'h7F) | ((k % 3 == 2) ? 8'h80 : 8'h00));
          send_beat(d, 8);
        end
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("t4_in_ready_fell", saw_stall, 1);
    wait_drain(100);
    check("t4_count", rx_q.size(), 12);
    check_rx(0, 64'h82_01_00, 3, 0);
    check_rx(1, 64'h85_04_03, 3, 0);
    check_rx(2, 64'h8A_09_08_07_06, 5, 0);

    // 5: asynchronous reset while a field is held and bytes 10 11 are buffered.
    rx_q.delete();
    out_ready = 1'b0;
    send_beat(64'h0000_0000_0011_1085, 3);
    repeat (2) @(posedge clk);
    #3;
    check("t5_held_before_reset", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_data", out_data, 0);
    check("t5_rst_out_len", out_len, 0);
    check("t5_rst_out_err", out_err, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    check("t5_rst_in_ready", in_ready, 1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(64'h95, 1);
    wait_drain(50);
    check("t5_count", rx_q.size(), 1);
    check_rx(0, 64'h95, 1, 0);

    // 6: 200 random fields, random keep, random out_ready, many ring wraps.
    rx_q.delete();
    stream.delete();
    for (int f = 0; f < 200; f++) begin
      int len = $urandom_range(1, 8);
      for (int i = 0; i < len - 1; i++) stream.push_back(8'($urandom_range(0, 127)));
      stream.push_back(8'(8'h80 | $urandom_range(0, 127)));
    end
    total_bytes = stream.size();
    done = 0;
    fork
      begin
        while (stream.size() != 0) begin
          logic [63:0] d;
          int keep;
          d = {$urandom, $urandom};
          keep = $urandom_range(1, 8);
          if (keep > stream.size()) keep = stream.size();
          for (int k = 0; k < keep; k++) d[8*k +: 8] = stream.pop_front();
          send_beat(d, keep);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(2000);
    check("t6_wrapped", total_bytes > 64, 1);
    check("t6_count", rx_q.size(), 200);
    n_err = 0;
    foreach (rx_q[i]) if (rx_q[i].err) n_err++;
    check("t6_no_err", n_err, 0);
    check("t6_drop_cnt", drop_cnt, model_drops);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fast_field_extractor.md
# fast_field_extractor

Parametrised successor to the FAST field aligner. It accepts FAST-encoded beats of `BEAT_BYTES` bytes over a valid/ready handshake and buffers them in a byte ring. It locates stop bits (bit 7 of each byte) and emits one complete, left-aligned field per cycle over a second valid/ready handshake. It sits between the feed deserialiser and the FAST field decoder, and adds partial-beat input, backpressure, ring wrap and overlong-field error recovery.

## Interface
- `BEAT_BYTES`, 8: bytes per input beat; byte k is `in_data[8k+7:8k]`; byte 0 is first on the wire.
- `RING_BYTES`, 32: ring depth. Power of two, ≥ `2*BEAT_BYTES`, ≥ `MAX_FIELD_BYTES+BEAT_BYTES`.
- `MAX_FIELD_BYTES`, 8: longest legal field in bytes.
- `CNT_W`, 16: width of the drop counter.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: a beat can be accepted.
- `in_data`, in, `8*BEAT_BYTES`: raw FAST bytes.
- `in_keep`, in, `$clog2(BEAT_BYTES+1)`: number of valid low bytes, 1..`BEAT_BYTES`. A value of 0 is illegal.
- `out_valid`, out, 1: field valid.
- `out_ready`, in, 1: downstream accepts the field.
- `out_data`, out, `8*MAX_FIELD_BYTES`: field bytes. Byte 0 is at `[7:0]`; bytes at and above `out_len` are zero.
- `out_len`, out, `$clog2(MAX_FIELD_BYTES+1)`: field length in bytes, 1..`MAX_FIELD_BYTES`.
- `out_err`, out, 1: the field was truncated because it was overlong.
- `drop_cnt`, out, `CNT_W`: count of bytes discarded in DISCARD state. Saturating.

## Operation
- **Ring state:** `wr_ptr` and `rd_ptr` are `$clog2(RING_BYTES)+1` bits wide; the MSB is the wrap bit. `count = wr_ptr - rd_ptr`.
- **In handshake:** `in_ready = (RING_BYTES - count) >= BEAT_BYTES`. It uses the registered count only; there is no pop credit.
  - On `in_valid && in_ready`, bytes 0..`in_keep-1` are written at `wr_ptr` modulo `RING_BYTES`, and `wr_ptr += in_keep`.
- **Scan window:** the first `W = min(count, MAX_FIELD_BYTES)` bytes starting at `rd_ptr`. A priority encoder finds the lowest index s with stop bit = 1.
- **State SCAN:**
  - If a stop is found at s and the output register is free (`!out_valid || out_ready`):
    - load bytes 0..s into `out_data`, zero-fill the rest;
    - set `out_len = s+1`, `out_err = 0`;
    - set `rd_ptr += s+1`.
  - If there is no stop and `count >= MAX_FIELD_BYTES` and the output register is free:
    - load `MAX_FIELD_BYTES` bytes with `out_err = 1`;
    - set `rd_ptr += MAX_FIELD_BYTES`;
    - go to DISCARD.
  - Otherwise wait.
- **State DISCARD:** each cycle, scan all `min(count, BEAT_BYTES)` bytes.
  - If a stop is found at s: pop s+1 bytes, add s+1 to `drop_cnt`, and return to SCAN.
  - If no stop is found: pop all scanned bytes and add them to `drop_cnt`.
  - Nothing is emitted in this state.
- **Output register:** loads only when free. `out_*` are held stable while `out_valid && !out_ready`.
- **Simultaneous push and pop:** allowed in the same cycle; `count` updates as +pushed − popped.
- **Reset:**
  - pointers = 0, state = SCAN;
  - `out_valid`, `out_data`, `out_len`, `out_err` = 0; `drop_cnt` = 0;
  - `in_ready` = 1 (follows from count = 0).
  - Assertion mid-operation discards all buffered bytes, including any partial field.

## Timing
- **Latency:** a beat accepted at edge N that completes a field raises `out_valid` after edge N+1, i.e. one scan cycle.
- **Throughput:** at most one field per cycle. A beat holding k complete fields drains over k consecutive cycles when `out_ready` = 1.
- **Input stall:** `in_ready` drops when free space < `BEAT_BYTES` and recovers the cycle after pops free enough space.
- **Overlong field:** the error field appears one cycle after `count` reaches `MAX_FIELD_BYTES` with no stop in the window. DISCARD takes ⌈remaining bytes / `BEAT_BYTES`⌉ cycles.
- **Wrap-around:** pointers wrap modulo `2*RING_BYTES`. Full is `count == RING_BYTES`; empty is `count == 0`. The scan window reads across the wrap point transparently.

## Structure
- **Package `fast_pkg`:**
  - `STOP_BIT = 7`;
  - `typedef enum {SCAN, DISCARD} fx_state_t`;
  - function `first_stop(window, n)` returning `{found, index}`.
- **Sub-module `fast_stop_scan`:** parametrised window width; a combinational priority encoder over the stop bits of the rotated window. Instantiated once; DISCARD uses the low `BEAT_BYTES` lanes of the same window.
- **Top level:** contains the ring registers, pointer and count logic, state register, output register and `drop_cnt`.

## Test plan
Parameters 8/32/8 unless stated.

1. **Multiple fields in one beat:** one beat `01 82 83 04 05 86 07 88`, keep=8, `out_ready`=1 → four consecutive outputs:
   - {01 82} len 2;
   - {83} len 1;
   - {04 05 86} len 3;
   - {07 88} len 2;
   - all with `out_err`=0; first `out_valid` one cycle after acceptance.
2. **Field split across partial beats:** beat `10 11 12` keep=3, then beat `13 94` keep=2 → a single field {10 11 12 13 94}, len 5, emitted one cycle after the second beat.
3. **Overlong field and discard:** bytes `00..08`, then `89 81` → field {00..07} len 8 with `out_err`=1; bytes 08 and 89 are dropped; then field {81} len 1 with `out_err`=0; `drop_cnt`=2.
4. **Backpressure:** hold `out_ready`=0 for 10 cycles under continuous full beats →
   - `in_ready` falls once free space < 8;
   - `out_*` stay stable;
   - after release, all fields arrive in order with no loss or duplication.
5. **Reset mid-field:** pulse `rst_n` low asynchronously while bytes `10 11` are buffered →
   - all outputs are 0 immediately and `in_ready`=1;
   - the next beat `95` yields {95} len 1.
6. **Ring wrap:** stream 200 random-length fields (1..8 bytes) with random `in_keep` and random `out_ready` → scoreboard match, with multiple ring wraps and no `out_err`.
